// File: rtl/scsi_fifo_packer.sv
// Eight-longword FIFO between the SCSI byte datapath and the host memory bus.
// Packs SCSI bytes into big-endian longwords on fill; unpacks longwords into bytes on drain.
module scsi_fifo_packer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLUSH,
    input  logic          DIR,
    input  logic [7:0]    BYTE_IN,
    input  logic          BYTE_WR,
    input  logic          BYTE_RD,
    output logic [7:0]    BYTE_OUT,
    output logic          BO0,
    output logic          BO1,
    input  logic [31:0]   LW_IN,
    input  logic          LW_WR,
    input  logic          LW_RD,
    output logic [31:0]   LW_OUT,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   COUNT
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    lane_q, lane_d;
    logic          dir_q, dir_d;

    logic          full, empty, dir_chg;
    logic          byte_wr_ok, byte_rd_ok, lw_wr_ok, lw_rd_ok;
    logic          push, pop;
    logic [4:0]    lane_sh;

    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        dir_chg = (DIR != dir_q);
        // Lane 0 is the MSB byte, so the bit offset is (3 - lane) * 8.
        lane_sh = {~lane_q, 3'b000};

        // Byte strobes are held off on the DIR-change cycle because the lane is being cleared.
        byte_wr_ok = DIR  && BYTE_WR && !full  && !dir_chg;
        byte_rd_ok = !DIR && BYTE_RD && !empty && !dir_chg;
        lw_wr_ok   = !DIR && LW_WR   && !full;
        lw_rd_ok   = DIR  && LW_RD   && !empty;

        push = lw_wr_ok || (byte_wr_ok && lane_q == 2'd3);
        pop  = lw_rd_ok || (byte_rd_ok && lane_q == 2'd3);

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        lane_d  = lane_q;
        dir_d   = DIR;

        if (FLUSH) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            lane_d  = '0;
        end else begin
            if (dir_chg) begin
                lane_d = '0;
            end else if (byte_wr_ok || byte_rd_ok) begin
                lane_d = lane_q + 2'd1;
            end
            if (push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            lane_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            lane_q  <= lane_d;
            dir_q   <= dir_d;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (!RST && !FLUSH) begin
            if (lw_wr_ok) begin
                mem[wptr_q] <= LW_IN;
            end else if (byte_wr_ok) begin
                mem[wptr_q][lane_sh +: 8] <= BYTE_IN;
            end
        end
    end

    assign LW_OUT   = mem[rptr_q];
    assign BYTE_OUT = mem[rptr_q][lane_sh +: 8];
    assign BO0      = lane_q[0];
    assign BO1      = lane_q[1];
    assign FULL     = full;
    assign EMPTY    = empty;
    assign COUNT    = count_q;

endmodule
